// File: rtl/parity_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : parity_pkg                                                        |
// | Desc   : State encodings and parity-mode constants for the frame checker   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // total is the XOR of all data bits and the received parity bit
    function automatic logic parity_error(input logic total, input logic odd_mode);
        return (odd_mode == PAR_ODD) ? ~total : total;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sat_counter                                                       |
// | Desc   : Saturating event counter with synchronous clear                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    // A clear coinciding with an increment keeps that event rather than dropping it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : parity_frame_checker                                              |
// | Desc   : Serial LSB-first frame deserialiser with even/odd parity check    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_vld,
    input  logic              odd,
    input  logic              abort,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_vld,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int            CW     = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] c_last = CW'(DATA_W - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;
    logic               r_odd;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_frame_vld;
    logic               r_par_err;

    logic               w_err;
    logic               w_err_evt;

    assign w_err     = parity_error(r_par ^ bit_in, r_odd);
    assign w_err_evt = (r_state == ST_PAR) && bit_vld && !abort && w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_odd       <= PAR_EVEN;
            r_data_out  <= '0;
            r_frame_vld <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_frame_vld <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_par   <= 1'b0;
            end else if (bit_vld) begin
                case (r_state)
                    ST_IDLE, ST_DATA: begin
                        // r_cnt is zero in IDLE, so one indexed write covers both states
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_cnt == CW'(i)) begin
                                r_shift[i] <= bit_in;
                            end
                        end
                        if (r_state == ST_IDLE) begin
                            r_odd <= odd;
                            r_par <= bit_in;
                        end else begin
                            r_par <= r_par ^ bit_in;
                        end
                        if (r_cnt == c_last) begin
                            r_state <= ST_PAR;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_DATA;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    ST_PAR: begin
                        r_data_out  <= r_shift;
                        r_par_err   <= w_err;
                        r_frame_vld <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_par       <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err_evt),
        .clr   (cnt_clr),
        .count (err_cnt)
    );

    assign data_out  = r_data_out;
    assign frame_vld = r_frame_vld;
    assign par_err   = r_par_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_parity_frame_checker                                           |
// | Desc   : Scoreboard bench for parity_frame_checker (DATA_W=4, CNT_W=2)     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic       odd = 1'b0;
    logic       abort = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [3:0] data_out;
    logic       frame_vld;
    logic       par_err;
    logic [1:0] err_cnt;
    logic       busy;

    typedef struct {
        logic [3:0] d;
        logic       e;
        logic [1:0] c;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] model_cnt = 2'd0;
    logic [3:0] last_d = 4'd0;

    parity_frame_checker #(
        .DATA_W (4),
        .CNT_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .odd       (odd),
        .abort     (abort),
        .cnt_clr   (cnt_clr),
        .data_out  (data_out),
        .frame_vld (frame_vld),
        .par_err   (par_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One input cycle: drive at negedge, sample busy at the following negedge
    task automatic drive_cycle(input logic b, input logic v, input logic o,
                               input logic ab, input logic clr, input logic exp_busy);
        bit_in  = b;
        bit_vld = v;
        odd     = o;
        abort   = ab;
        cnt_clr = clr;
        @(posedge clk);
        @(negedge clk);
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic idle(input int n);
        bit_vld = 1'b0;
        abort   = 1'b0;
        cnt_clr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic mode,
                              input int gap_pct, input logic clr_last);
        exp_t e;
        int   ones;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++)
                drive_cycle(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0, i != 0);
            drive_cycle(d[i], 1'b1, (i == 0) ? mode : 1'($urandom), 1'b0, 1'b0, 1'b1);
        end
        for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++)
            drive_cycle(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1);
        ones = $countones(d) + int'(p);
        e.e  = mode ? (ones % 2 == 0) : (ones % 2 == 1);
        if (clr_last)
            model_cnt = e.e ? 2'd1 : 2'd0;
        else if (e.e && model_cnt != 2'd3)
            model_cnt = model_cnt + 2'd1;
        e.d = d;
        e.c = model_cnt;
        q.push_back(e);
        last_d = d;
        drive_cycle(p, 1'b1, 1'($urandom), 1'b0, clr_last, 1'b0);
        chk("frame_vld_latency", 32'(frame_vld), 32'd1);
        bit_vld = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic abort_after(input int k);
        for (int i = 0; i < k; i++)
            drive_cycle(1'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1);
        drive_cycle(1'($urandom), 1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
        chk("abort_hold_data", 32'(data_out), 32'(last_d));
        abort   = 1'b0;
        bit_vld = 1'b0;
    endtask

    task automatic clear_cnt();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        model_cnt = 2'd0;
        chk("cnt_clr_alone", 32'(err_cnt), 32'd0);
        cnt_clr = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && frame_vld) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame_vld: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e.d));
                chk("par_err", 32'(par_err), 32'(mon_e.e));
                chk("err_cnt", 32'(err_cnt), 32'(mon_e.c));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_frame_vld", 32'(frame_vld), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(2);

        // Basic even/odd frames
        send_frame(4'b1010, 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        send_frame(4'b0111, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        send_frame(4'b0111, 1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // Back-to-back frames, then a frame with gaps
        send_frame(4'b1100, 1'b1, 1'b0, 0, 1'b0);
        send_frame(4'b0011, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        send_frame(4'b1001, 1'b0, 1'b0, 60, 1'b0);
        idle(2);

        // Abort mid-frame then a clean frame
        abort_after(2);
        send_frame(4'b0101, 1'b1, 1'b1, 0, 1'b0);
        idle(2);

        // Saturation and clear
        clear_cnt();
        for (int i = 0; i < 5; i++) begin
            send_frame(4'b0111, 1'b0, 1'b0, 0, 1'b0);
            idle(1);
        end
        send_frame(4'b0001, 1'b0, 1'b0, 0, 1'b1);
        idle(1);
        clear_cnt();

        // Randomised traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) abort_after($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) clear_cnt();
            send_frame(4'($urandom), 1'($urandom), 1'($urandom), 25,
                       $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Asynchronous reset between clock edges in the middle of a frame
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        bit_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_data_out", 32'(data_out), 32'd0);
        chk("arst_frame_vld", 32'(frame_vld), 32'd0);
        chk("arst_par_err", 32'(par_err), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        q.delete();
        model_cnt = 2'd0;
        last_d    = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        send_frame(4'b1110, 1'b0, 1'b1, 0, 1'b0);
        idle(3);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
